// File: rtl/alu_arbiter_if.sv
// +----------------------------------------------------------------------+
// | alu_arbiter_if                                                       |
// | Valid/ready request and response bundle for the two ALU requesters. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface alu_arbiter_if;
  logic       req0_valid;
  logic       req1_valid;
  logic [3:0] req0_op;
  logic [3:0] req1_op;
  logic [7:0] req0_a;
  logic [7:0] req0_b;
  logic [7:0] req1_a;
  logic [7:0] req1_b;
  logic       req0_ready;
  logic       req1_ready;
  logic       rsp0_valid;
  logic       rsp1_valid;
  logic       rsp0_ready;
  logic       rsp1_ready;
  logic [7:0] rsp0_z;
  logic [7:0] rsp1_z;
  logic       rsp0_zero;
  logic       rsp1_zero;

  modport master (
    output req0_valid, req1_valid, req0_op, req1_op,
    output req0_a, req0_b, req1_a, req1_b,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    input  rsp0_z, rsp1_z, rsp0_zero, rsp1_zero
  );

  modport slave (
    input  req0_valid, req1_valid, req0_op, req1_op,
    input  req0_a, req0_b, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    output rsp0_z, rsp1_z, rsp0_zero, rsp1_zero
  );
endinterface

`default_nettype wire

// File: rtl/alu_arbiter.sv
// +----------------------------------------------------------------------+
// | alu_arbiter                                                          |
// | Round-robin sharing of one 8-bit ALU between two valid/ready users. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module alu (
  input  wire logic [3:0] i_op,
  input  wire logic [7:0] i_a,
  input  wire logic [7:0] i_b,
  output logic      [7:0] o_z,
  output logic            o_zero
);
  // op[3] inverts A, op[2] inverts B and supplies the carry-in, op[1:0] selects
  logic [7:0] w_a;
  logic [7:0] w_b;
  logic [7:0] w_sum;

  always_comb begin
    w_a   = i_op[3] ? ~i_a : i_a;
    w_b   = i_op[2] ? ~i_b : i_b;
    w_sum = w_a + w_b + {7'd0, i_op[2]};
    case (i_op[1:0])
      2'b00:   o_z = w_a & w_b;
      2'b01:   o_z = w_a | w_b;
      2'b10:   o_z = w_sum;
      default: o_z = {7'd0, w_sum[7]};
    endcase
    o_zero = (o_z == 8'd0);
  end
endmodule

module alu_arbiter (
  input wire logic         clk,
  input wire logic         rst,
  alu_arbiter_if.slave     bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_gnt;
  logic       r_prio;
  logic [3:0] r_op;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [7:0] r_z;
  logic       r_zero;

  logic       w_any;
  logic       w_pick;
  logic       w_rsp_take;
  logic       w_op_legal;
  logic [7:0] w_alu_z;
  logic       w_alu_zero;

  alu u_alu (
    .i_op   (r_op),
    .i_a    (r_a),
    .i_b    (r_b),
    .o_z    (w_alu_z),
    .o_zero (w_alu_zero)
  );

  always_comb begin
    w_any      = bus.req0_valid | bus.req1_valid;
    w_pick     = (bus.req0_valid & bus.req1_valid) ? r_prio : bus.req1_valid;
    w_rsp_take = r_gnt ? bus.rsp1_ready : bus.rsp0_ready;
    case (r_op)
      4'b0000, 4'b0001, 4'b0010,
      4'b0110, 4'b0111, 4'b1100: w_op_legal = 1'b1;
      default:                   w_op_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Ready is masked by rst so a reset cycle never completes a handshake
        if (w_any && !rst) begin
          bus.req0_ready = ~w_pick;
          bus.req1_ready = w_pick;
          w_state_nxt    = S_EXEC;
        end
      end
      S_EXEC: w_state_nxt = S_RESP;
      S_RESP: begin
        bus.rsp0_valid = ~r_gnt;
        bus.rsp1_valid = r_gnt;
        if (w_rsp_take) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    bus.rsp0_z    = bus.rsp0_valid ? r_z : 8'd0;
    bus.rsp1_z    = bus.rsp1_valid ? r_z : 8'd0;
    bus.rsp0_zero = bus.rsp0_valid & r_zero;
    bus.rsp1_zero = bus.rsp1_valid & r_zero;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_gnt   <= 1'b0;
      r_prio  <= 1'b0;
      r_op    <= 4'd0;
      r_a     <= 8'd0;
      r_b     <= 8'd0;
      r_z     <= 8'd0;
      r_zero  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt <= w_pick;
            r_op  <= w_pick ? bus.req1_op : bus.req0_op;
            r_a   <= w_pick ? bus.req1_a  : bus.req0_a;
            r_b   <= w_pick ? bus.req1_b  : bus.req0_b;
          end
        end
        S_EXEC: begin
          r_z    <= w_op_legal ? w_alu_z : 8'd0;
          r_zero <= w_op_legal ? w_alu_zero : 1'b1;
        end
        S_RESP: begin
          if (w_rsp_take) r_prio <= ~r_gnt;
        end
        default: ;
      endcase
    end
  end
endmodule

`default_nettype wire
